cordic_phase_gen: RTL and testbench

Upstream driver for the CORDIC rotator: a phase-accumulator sequencer that generates the 32-bit angle stream plus the constant Xin/Yin seed. Bursts or runs continuously under a config handshake. Carries a valid/last token through a delay line matched to the CORDIC pipeline depth, so downstream logic sees sample_valid aligned with the rotator's sine/cosine.

---
 rtl/cordic_phase_gen.sv | 206 ++++++++++++++++++++
 tb/tb_cordic_phase_gen.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cordic_phase_gen.sv
// -----------------------------------------------------------------------------
// cordic_phase_gen
//
// Phase-accumulator sequencer feeding a pipelined CORDIC rotator. Emits one
// 32-bit angle per cycle while running, plus the constant Xin/Yin seed, and
// carries a {valid, last} token through a delay line whose depth equals the
// rotator latency. sample_valid / sample_last / done therefore line up with
// the rotator's sine/cosine outputs.
//
// States: IDLE (config accepted, waiting for start), RUN (one angle issued
// per cycle), DRAIN (waits for the final token to leave the delay line).
//
// Optional build macro: CORDIC_PHASE_DITHER_EN
//   defined   -> a 16-bit Fibonacci LFSR (taps 16,14,13,11, seed 0xACE1)
//                adds its low byte to the issued angle as phase dither; the
//                accumulator itself is untouched.
//   undefined -> angle is exactly the accumulator.
//
// Parameters:
//   WIDTH    width of Xin/Yin
//   X_SCALE  constant driven on Xin (gain-compensated amplitude)
//   LATENCY  rotator latency in clocks = delay-line depth (>= 1)
//
// Ports:
//   clock, reset          rising-edge clock, synchronous active-high reset
//   cfg_valid/cfg_ready   config handshake (ready only in IDLE)
//   cfg_ftw               phase step per sample (2^32 = 360 deg)
//   cfg_phase             start phase
//   cfg_count             samples per burst, 0 = continuous until stop
//   start / stop          begin run (IDLE) / end run (RUN)
//   busy                  high in RUN or DRAIN
//   angle                 angle to the rotator
//   Xin / Yin             constant X_SCALE / 0
//   sample_valid/_last    rotator output qualifiers, LATENCY after issue
//   done                  one-cycle pulse with the final sample_valid
// -----------------------------------------------------------------------------
module cordic_phase_gen #(
    parameter int WIDTH   = 16,
    parameter int X_SCALE = 19429,
    parameter int LATENCY = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [31:0]      cfg_ftw,
    input  logic [31:0]      cfg_phase,
    input  logic [15:0]      cfg_count,
    input  logic             start,
    input  logic             stop,
    output logic             busy,
    output logic [31:0]      angle,
    output logic [WIDTH-1:0] Xin,
    output logic [WIDTH-1:0] Yin,
    output logic             sample_valid,
    output logic             sample_last,
    output logic             done
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN
    } state_t;

    // Drain counter only needs to reach LATENCY-1.
    localparam int DCW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    state_t             state_q,     state_d;
    logic [31:0]        ftw_q,       ftw_d;
    logic [31:0]        phase_q,     phase_d;
    logic [15:0]        count_q,     count_d;
    logic [31:0]        acc_q,       acc_d;
    logic [15:0]        issued_q,    issued_d;
    logic [DCW-1:0]     drain_q,     drain_d;
    logic [LATENCY-1:0] dly_valid_q, dly_valid_d;
    logic [LATENCY-1:0] dly_last_q,  dly_last_d;

    logic issue_valid;
    logic issue_last;

`ifdef CORDIC_PHASE_DITHER_EN
    logic [15:0] lfsr_q, lfsr_d;
    logic        lfsr_fb;
    assign lfsr_fb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
`endif

    // Every RUN cycle issues one angle; the last one is flagged either by
    // stop or by reaching the programmed count (both at once still yield a
    // single last token).
    assign issue_valid = (state_q == ST_RUN);
    assign issue_last  = issue_valid &
                         (stop | ((count_q != 16'd0) && (issued_q == count_q - 16'd1)));

    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        state_d  = state_q;
        ftw_d    = ftw_q;
        phase_d  = phase_q;
        count_d  = count_q;
        acc_d    = acc_q;
        issued_d = issued_q;
        drain_d  = drain_q;
`ifdef CORDIC_PHASE_DITHER_EN
        lfsr_d   = lfsr_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (cfg_valid) begin
                    ftw_d   = cfg_ftw;
                    phase_d = cfg_phase;
                    count_d = cfg_count;
                end
                if (start) begin
                    // A config accepted in the same cycle takes effect now.
                    acc_d    = cfg_valid ? cfg_phase : phase_q;
                    issued_d = 16'd0;
                    state_d  = ST_RUN;
                end
            end

            ST_RUN: begin
                issued_d = issued_q + 16'd1;
                if (issue_last) begin
                    // Accumulator stays put so angle holds the final value.
                    state_d = ST_DRAIN;
                    drain_d = DCW'(LATENCY - 1);
                end else begin
                    acc_d = acc_q + ftw_q;
`ifdef CORDIC_PHASE_DITHER_EN
                    lfsr_d = {lfsr_q[14:0], lfsr_fb};
`endif
                end
            end

            ST_DRAIN: begin
                if (drain_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    drain_d = drain_q - DCW'(1);
                end
            end

            default: state_d = ST_IDLE;
        endcase

        // Token delay line: stage 0 takes the current issue, the final stage
        // lines up with the rotator output.
        dly_valid_d[0] = issue_valid;
        dly_last_d[0]  = issue_last;
        for (int i = 1; i < LATENCY; i++) begin
            dly_valid_d[i] = dly_valid_q[i-1];
            dly_last_d[i]  = dly_last_q[i-1];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            ftw_q       <= '0;
            phase_q     <= '0;
            count_q     <= '0;
            acc_q       <= '0;
            issued_q    <= '0;
            drain_q     <= '0;
            // NOTE: the delay line is reset on purpose: a reset mid-run must
            // flush in-flight tokens so no stale sample_valid/done escapes.
            dly_valid_q <= '0;
            dly_last_q  <= '0;
`ifdef CORDIC_PHASE_DITHER_EN
            lfsr_q      <= 16'hACE1;
`endif
        end else begin
            // NOTE: non-blocking assignments so all flops update from the
            // same pre-edge values.
            state_q     <= state_d;
            ftw_q       <= ftw_d;
            phase_q     <= phase_d;
            count_q     <= count_d;
            acc_q       <= acc_d;
            issued_q    <= issued_d;
            drain_q     <= drain_d;
            dly_valid_q <= dly_valid_d;
            dly_last_q  <= dly_last_d;
`ifdef CORDIC_PHASE_DITHER_EN
            lfsr_q      <= lfsr_d;
`endif
        end
    end

`ifdef CORDIC_PHASE_DITHER_EN
    assign angle = acc_q + {24'd0, lfsr_q[7:0]};
`else
    assign angle = acc_q;
`endif

    assign cfg_ready    = (state_q == ST_IDLE);
    assign busy         = (state_q != ST_IDLE);
    assign Xin          = WIDTH'(X_SCALE);
    assign Yin          = '0;
    assign sample_valid = dly_valid_q[LATENCY-1];
    assign sample_last  = dly_valid_q[LATENCY-1] & dly_last_q[LATENCY-1];
    assign done         = dly_valid_q[LATENCY-1] & dly_last_q[LATENCY-1];

endmodule

// File: tb/tb_cordic_phase_gen.sv
// -----------------------------------------------------------------------------
// Self-checking bench for cordic_phase_gen (dither macro undefined).
// A behavioural model computes the k-th angle as phase + k*ftw and schedules
// expected {valid,last} tokens LATENCY cycles after each issue in cycle-keyed
// associative arrays; every cycle the DUT outputs are compared against it.
// Directed scenarios pin the model with hand-computed literals, then a long
// randomized phase exercises handshakes, stop, bursts and resets.
// -----------------------------------------------------------------------------
module tb_cordic_phase_gen;

    localparam int LAT = 16;

    logic        clock = 1'b0;
    logic        reset;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [31:0] cfg_ftw;
    logic [31:0] cfg_phase;
    logic [15:0] cfg_count;
    logic        start;
    logic        stop;
    logic        busy;
    logic [31:0] angle;
    logic [15:0] Xin;
    logic [15:0] Yin;
    logic        sample_valid;
    logic        sample_last;
    logic        done;

    cordic_phase_gen #(
        .WIDTH  (16),
        .X_SCALE(19429),
        .LATENCY(LAT)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_ftw     (cfg_ftw),
        .cfg_phase   (cfg_phase),
        .cfg_count   (cfg_count),
        .start       (start),
        .stop        (stop),
        .busy        (busy),
        .angle       (angle),
        .Xin         (Xin),
        .Yin         (Yin),
        .sample_valid(sample_valid),
        .sample_last (sample_last),
        .done        (done)
    );

    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Behavioural model state: mode 0 = idle, 1 = running, 2 = draining.
    int          m_mode = 0;
    logic [31:0] m_ftw = '0, m_phase = '0, m_angle = '0;
    logic [15:0] m_count = '0;
    int          m_k = 0;
    int          m_drain_end = 0;
    bit          exp_v [int];
    bit          exp_l [int];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got=0x%08h expected=0x%08h", name, cyc, got, exp);
        end
    endtask

    // Advance the model across one rising edge using the inputs sampled there.
    task automatic model_step();
        bit last;
        if (reset) begin
            m_mode  = 0;
            m_ftw   = '0;
            m_phase = '0;
            m_count = '0;
            m_angle = '0;
            exp_v.delete();
            exp_l.delete();
        end else begin
            case (m_mode)
                0: begin
                    if (cfg_valid) begin
                        m_ftw   = cfg_ftw;
                        m_phase = cfg_phase;
                        m_count = cfg_count;
                    end
                    if (start) begin
                        m_mode  = 1;
                        m_k     = 0;
                        m_angle = m_phase;
                    end
                end
                1: begin
                    last = stop || (m_count != 16'd0 && m_k + 1 == int'(m_count));
                    exp_v[cyc + LAT] = 1'b1;
                    exp_l[cyc + LAT] = last;
                    m_k++;
                    if (last) begin
                        m_mode      = 2;
                        m_drain_end = cyc + LAT;
                    end else begin
                        m_angle = m_phase + m_ftw * 32'(m_k);
                    end
                end
                default: begin
                    if (cyc == m_drain_end) m_mode = 0;
                end
            endcase
        end
    endtask

    task automatic compare();
        bit ev, el;
        ev = exp_v.exists(cyc);
        el = ev && exp_l[cyc];
        check("busy",         32'(busy),         32'(m_mode != 0));
        check("cfg_ready",    32'(cfg_ready),    32'(m_mode == 0));
        check("angle",        angle,             m_angle);
        check("sample_valid", 32'(sample_valid), 32'(ev));
        check("sample_last",  32'(sample_last & sample_valid), 32'(el));
        check("done",         32'(done),         32'(el));
        check("xin",          32'(Xin),          32'd19429);
        check("yin",          32'(Yin),          32'd0);
    endtask

    task automatic tick();
        @(posedge clock);
        model_step();
        cyc++;
        @(negedge clock);
        compare();
    endtask

    // Drive config + start in the current cycle; returns T, the start cycle.
    task automatic cfg_start(input logic [31:0] ftw, input logic [31:0] phase,
                             input logic [15:0] count, output int t_start);
        cfg_valid = 1'b1;
        cfg_ftw   = ftw;
        cfg_phase = phase;
        cfg_count = count;
        start     = 1'b1;
        t_start   = cyc;
        tick();
        cfg_valid = 1'b0;
        start     = 1'b0;
    endtask

    // Watch a run to completion (bounded) recording timing relative to T.
    task automatic watch(input int t_start, input int ncyc, output int nsv, output int ndone,
                         output int first_sv, output int done_at, output int idle_at);
        nsv = 0; ndone = 0; first_sv = -1; done_at = -1; idle_at = -1;
        for (int i = 0; i < ncyc; i++) begin
            tick();
            if (sample_valid) begin
                nsv++;
                if (first_sv < 0) first_sv = cyc - t_start;
            end
            if (done) begin
                ndone++;
                done_at = cyc - t_start;
            end
            if (!busy && idle_at < 0) idle_at = cyc - t_start;
        end
    endtask

    initial begin
        int t, nsv, ndone, first_sv, done_at, idle_at;
        logic [31:0] lit_a [4];
        logic [31:0] lit_w [3];

        reset = 1'b1; cfg_valid = 1'b0; start = 1'b0; stop = 1'b0;
        cfg_ftw = '0; cfg_phase = '0; cfg_count = '0;

        // Reset held three cycles.
        for (int i = 0; i < 3; i++) tick();
        check("rst_cfg_ready", 32'(cfg_ready),    32'd1);
        check("rst_busy",      32'(busy),         32'd0);
        check("rst_angle",     angle,             32'd0);
        check("rst_xin",       32'(Xin),          32'd19429);
        check("rst_yin",       32'(Yin),          32'd0);
        check("rst_valid",     32'(sample_valid), 32'd0);
        check("rst_done",      32'(done),         32'd0);
        reset = 1'b0;
        tick();

        // Four-sample burst.
        lit_a[0] = 32'h00000000; lit_a[1] = 32'h0AAAAAAB;
        lit_a[2] = 32'h15555556; lit_a[3] = 32'h20000001;
        cfg_start(32'h0AAAAAAB, 32'h0, 16'd4, t);
        for (int j = 0; j < 4; j++) begin
            check("burst_angle", angle, lit_a[j]);
            if (j < 3) tick();
        end
        watch(t, 40, nsv, ndone, first_sv, done_at, idle_at);
        check("burst_nsv",     32'(nsv),      32'd4);
        check("burst_first",   32'(first_sv), 32'd17);
        check("burst_ndone",   32'(ndone),    32'd1);
        check("burst_done_at", 32'(done_at),  32'd20);
        check("burst_idle_at", 32'(idle_at),  32'd21);

        // Accumulator wrap.
        lit_w[0] = 32'hC0000000; lit_w[1] = 32'h00000000; lit_w[2] = 32'h40000000;
        cfg_start(32'h40000000, 32'hC0000000, 16'd3, t);
        for (int j = 0; j < 3; j++) begin
            check("wrap_angle", angle, lit_w[j]);
            if (j < 2) tick();
        end
        watch(t, 40, nsv, ndone, first_sv, done_at, idle_at);
        check("wrap_nsv",   32'(nsv),   32'd3);
        check("wrap_ndone", 32'(ndone), 32'd1);

        // Continuous run ended by stop during the 10th issue cycle.
        cfg_start(32'd1, 32'd0, 16'd0, t);
        for (int j = 0; j < 9; j++) tick();
        check("stop_angle10", angle, 32'd9);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("stop_hold", angle, 32'd9);
        watch(t, 40, nsv, ndone, first_sv, done_at, idle_at);
        check("stop_nsv",     32'(nsv),     32'd10);
        check("stop_ndone",   32'(ndone),   32'd1);
        check("stop_done_at", 32'(done_at), 32'd26);
        check("stop_final",   angle,        32'd9);

        // Reset five cycles into a 20-sample run.
        cfg_start(32'h01234567, 32'd0, 16'd20, t);
        for (int j = 0; j < 4; j++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rrun_cfg_ready", 32'(cfg_ready), 32'd1);
        nsv = 0; ndone = 0;
        for (int j = 0; j < LAT + 5; j++) begin
            if (sample_valid) nsv++;
            if (done) ndone++;
            tick();
        end
        check("rrun_nsv",   32'(nsv),   32'd0);
        check("rrun_ndone", 32'(ndone), 32'd0);

        // Config offered during RUN is refused; next run keeps the old ftw.
        cfg_start(32'h00000100, 32'h00001000, 16'd3, t);
        cfg_valid = 1'b1;
        cfg_ftw   = 32'h00000005;
        cfg_phase = 32'h00777777;
        cfg_count = 16'd9;
        check("run_cfg_ready", 32'(cfg_ready), 32'd0);
        tick();
        tick();
        cfg_valid = 1'b0;
        watch(t, 40, nsv, ndone, first_sv, done_at, idle_at);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("old_cfg_a0", angle, 32'h00001000);
        tick();
        check("old_cfg_a1", angle, 32'h00001100);
        watch(t, 40, nsv, ndone, first_sv, done_at, idle_at);
        check("old_cfg_idle", 32'(busy), 32'd0);

        // Randomized traffic checked cycle by cycle against the model.
        for (int i = 0; i < 4000; i++) begin
            reset     = ($urandom_range(0, 299) == 0);
            cfg_valid = ($urandom_range(0, 3) == 0);
            cfg_ftw   = ($urandom_range(0, 1) == 0) ? $urandom() : 32'($urandom_range(0, 255));
            cfg_phase = $urandom();
            cfg_count = 16'($urandom_range(0, 24));
            start     = ($urandom_range(0, 7) == 0);
            stop      = ($urandom_range(0, 39) == 0);
            tick();
        end
        reset = 1'b0; cfg_valid = 1'b0; start = 1'b0; stop = 1'b1;
        for (int i = 0; i < LAT + 4; i++) tick();
        stop = 1'b0;
        for (int i = 0; i < 4; i++) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
